// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - rv32imc writeback stage: dmem response wait, load alignment, regfile write, RVFI commit
// Optional performance counters are built when WB_PERF_CNT_EN is defined.

typedef struct packed {
  logic        valid;
  logic [63:0] order;
  logic [31:0] insn;
  logic [31:0] pc_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
} rvfi_t;

typedef struct packed {
  logic       mem_read;
  logic       mem_write;
  logic [2:0] funct3;
} mem_ctrl_t;

typedef struct packed {
  logic regf_we;
} wb_ctrl_t;

typedef struct packed {
  logic [4:0]  rd_addr;
  logic [31:0] alu_out;
  mem_ctrl_t   mem_ctrl;
  wb_ctrl_t    wb_ctrl;
  rvfi_t       rvfi;
} mem_stage_t;

module wb_stage #(
  parameter int unsigned RESP_TIMEOUT = 256,
  parameter int unsigned PERF_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stall,
  input  mem_stage_t        mem_stage_reg,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              wb_busy,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output rvfi_t             wb_rvfi,
  output logic              timeout_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_load_wait
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CNT_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (RESP_TIMEOUT > 0) ? CNT_W'(RESP_TIMEOUT - 1) : '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             entry_new;
  logic [CNT_W-1:0] wait_cnt;
  logic             new_entry;
  logic             memop;
  logic             is_load;
  logic             commit;
  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;
  rvfi_t            rvfi_nxt;

  // mem_stage_reg was reloaded at the last edge iff mem_stall was low there.
  assign new_entry = entry_new & mem_stage_reg.rvfi.valid;
  assign memop     = mem_stage_reg.mem_ctrl.mem_read | mem_stage_reg.mem_ctrl.mem_write;
  assign is_load   = mem_stage_reg.mem_ctrl.mem_read;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    wb_busy   = 1'b0;
    case (state)
      S_IDLE: begin
        if (new_entry) begin
          if (!memop || dmem_resp) begin
            commit    = 1'b1;
            state_nxt = mem_stall ? S_DONE : S_IDLE;
          end else begin
            wb_busy   = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wb_busy = !dmem_resp;
        if (dmem_resp) begin
          commit    = 1'b1;
          state_nxt = mem_stall ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!mem_stall) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign off      = mem_stage_reg.alu_out[1:0];
  assign byte_sel = dmem_rdata[8*off +: 8];
  assign half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    case (mem_stage_reg.mem_ctrl.funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  assign rf_we    = commit & mem_stage_reg.wb_ctrl.regf_we & (mem_stage_reg.rd_addr != 5'd0);
  assign rf_waddr = commit ? mem_stage_reg.rd_addr : 5'd0;
  assign rf_wdata = rf_we ? (is_load ? load_data : mem_stage_reg.alu_out) : 32'h0;

  always_comb begin
    rvfi_nxt           = mem_stage_reg.rvfi;
    rvfi_nxt.valid     = 1'b1;
    rvfi_nxt.rd_addr   = rf_we ? mem_stage_reg.rd_addr : 5'd0;
    rvfi_nxt.rd_wdata  = rf_wdata;
    rvfi_nxt.mem_rdata = is_load ? dmem_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      entry_new <= 1'b0;
      wb_rvfi   <= '0;
    end else begin
      state     <= state_nxt;
      entry_new <= !mem_stall;
      wb_rvfi   <= commit ? rvfi_nxt : '0;
    end
  end

  // Counter saturates at CNT_LAST; the error flag is sticky and never aborts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state == S_WAIT) begin
      if (RESP_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
        timeout_err <= 1'b1;
      end
      if (state_nxt != S_WAIT) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired   <= '0;
      perf_load_wait <= '0;
    end else begin
      if (commit) begin
        perf_retired <= perf_retired + 1'b1;
      end
      if (state == S_WAIT && is_load) begin
        perf_load_wait <= perf_load_wait + 1'b1;
      end
    end
  end
`else
  logic [PERF_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_stall;
  logic        mem_stall;
  mem_stage_t  ms;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        wb_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  rvfi_t       wb_rvfi;
  logic        timeout_err;
`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired;
  logic [63:0] perf_load_wait;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_stall = wb_busy | ext_stall;

  wb_stage #(.RESP_TIMEOUT(4), .PERF_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_stall     (mem_stall),
    .mem_stage_reg (ms),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .wb_busy       (wb_busy),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .wb_rvfi       (wb_rvfi),
    .timeout_err   (timeout_err)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_retired  (perf_retired),
    .perf_load_wait(perf_load_wait)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic        rd_m;
    logic        wr_m;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_wd;
    int          exp_busy;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [2:0] f3, input logic rd_m, input logic wr_m,
                              input logic we, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] rdata, input int delay, input logic exp_we,
                              input logic [31:0] exp_wd, input int exp_busy);
    vec_t v;
    v.f3 = f3; v.rd_m = rd_m; v.wr_m = wr_m; v.we = we; v.rd = rd;
    v.alu = alu; v.rdata = rdata; v.delay = delay;
    v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int          busy_cnt;
    logic        got_we;
    logic [4:0]  got_wa;
    logic [31:0] got_wd;
    logic [31:0] pc;
    pc = 32'h100 + 32'(i * 4);
    ms = '0;
    ms.rd_addr           = v.rd;
    ms.alu_out           = v.alu;
    ms.mem_ctrl.mem_read  = v.rd_m;
    ms.mem_ctrl.mem_write = v.wr_m;
    ms.mem_ctrl.funct3    = v.f3;
    ms.wb_ctrl.regf_we   = v.we;
    ms.rvfi.valid        = 1'b1;
    ms.rvfi.pc_rdata     = pc;
    ms.rvfi.rd_addr      = v.rd;
    ms.rvfi.mem_addr     = v.alu;
    busy_cnt = 0;
    got_we = 1'b0; got_wa = 5'd0; got_wd = 32'h0;
    for (int k = 0; k <= v.delay; k++) begin
      dmem_resp  = (k == v.delay);
      dmem_rdata = (k == v.delay) ? v.rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (wb_busy) busy_cnt++;
      if (k == v.delay) begin
        got_we = rf_we; got_wa = rf_waddr; got_wd = rf_wdata;
      end
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
    ms.rvfi.valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d.busy_cycles", i), 32'(busy_cnt), 32'(v.exp_busy));
    chk($sformatf("v%0d.rf_we", i), {31'h0, got_we}, {31'h0, v.exp_we});
    chk($sformatf("v%0d.rf_wdata", i), got_wd, v.exp_wd);
    if (v.exp_we) chk($sformatf("v%0d.rf_waddr", i), {27'h0, got_wa}, {27'h0, v.rd});
    chk($sformatf("v%0d.rvfi.valid", i), {31'h0, wb_rvfi.valid}, 32'h1);
    chk($sformatf("v%0d.rvfi.rd_wdata", i), wb_rvfi.rd_wdata, v.exp_wd);
    chk($sformatf("v%0d.rvfi.rd_addr", i), {27'h0, wb_rvfi.rd_addr}, v.exp_we ? {27'h0, v.rd} : 32'h0);
    chk($sformatf("v%0d.rvfi.mem_rdata", i), wb_rvfi.mem_rdata, v.rd_m ? v.rdata : 32'h0);
    chk($sformatf("v%0d.rvfi.pc", i), wb_rvfi.pc_rdata, pc);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d.rvfi.valid_drop", i), {31'h0, wb_rvfi.valid}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    int we_seen;
    int busy_seen;

    vecs[0]  = mk(3'b000, 0, 0, 1, 5'd5,  32'h0000_1234, 32'h0,         0, 1, 32'h0000_1234, 0);
    vecs[1]  = mk(3'b000, 1, 0, 1, 5'd6,  32'h0000_1003, 32'h80FF_0000, 3, 1, 32'hFFFF_FF80, 3);
    vecs[2]  = mk(3'b101, 1, 0, 1, 5'd7,  32'h0000_2002, 32'hBEEF_1234, 0, 1, 32'h0000_BEEF, 0);
    vecs[3]  = mk(3'b010, 1, 0, 1, 5'd8,  32'h0000_3000, 32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 1);
    vecs[4]  = mk(3'b100, 1, 0, 1, 5'd9,  32'h0000_4001, 32'h1234_5678, 2, 1, 32'h0000_0056, 2);
    vecs[5]  = mk(3'b001, 1, 0, 1, 5'd10, 32'h0000_5000, 32'h0000_8001, 0, 1, 32'hFFFF_8001, 0);
    vecs[6]  = mk(3'b000, 1, 0, 1, 5'd11, 32'h0000_5004, 32'hFFFF_FF7F, 0, 1, 32'h0000_007F, 0);
    vecs[7]  = mk(3'b010, 1, 0, 1, 5'd0,  32'h0000_6000, 32'h1111_2222, 1, 0, 32'h0,         1);
    vecs[8]  = mk(3'b000, 0, 0, 0, 5'd3,  32'h0000_00AA, 32'h0,         0, 0, 32'h0,         0);
    vecs[9]  = mk(3'b010, 0, 1, 0, 5'd0,  32'h0000_7008, 32'h5555_5555, 2, 0, 32'h0,         2);
    vecs[10] = mk(3'b101, 1, 0, 1, 5'd12, 32'h0000_7000, 32'hFFFF_8000, 0, 1, 32'h0000_8000, 0);
    vecs[11] = mk(3'b001, 1, 0, 1, 5'd13, 32'h0000_7002, 32'h8765_4321, 1, 1, 32'hFFFF_8765, 1);

    rst_n = 1'b0; ext_stall = 1'b0; ms = '0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.wb_busy", {31'h0, wb_busy}, 32'h0);
    chk("rst.rf_we", {31'h0, rf_we}, 32'h0);
    chk("rst.rf_waddr", {27'h0, rf_waddr}, 32'h0);
    chk("rst.rf_wdata", rf_wdata, 32'h0);
    chk("rst.rvfi_nonzero", {31'h0, (wb_rvfi != '0)}, 32'h0);
    chk("rst.timeout_err", {31'h0, timeout_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end
    chk("vec.timeout_err", {31'h0, timeout_err}, 32'h0);

    // Store commits while the pipeline is held 4 cycles; a stray response lands in DONE.
    ms = '0;
    ms.mem_ctrl.mem_write = 1'b1;
    ms.mem_ctrl.funct3    = 3'b010;
    ms.alu_out            = 32'h0000_9000;
    ms.rvfi.valid         = 1'b1;
    ms.rvfi.pc_rdata      = 32'h200;
    dmem_resp = 1'b1; dmem_rdata = 32'h0; ext_stall = 1'b1;
    pulses = 0; we_seen = 0; busy_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rf_we) we_seen++;
      if (wb_busy) busy_seen++;
      if (wb_rvfi.valid) pulses++;
      @(posedge clk); #1;
      dmem_resp = (k == 1);
    end
    ext_stall = 1'b0; dmem_resp = 1'b0;
    @(negedge clk);
    if (rf_we) we_seen++;
    if (wb_busy) busy_seen++;
    if (wb_rvfi.valid) pulses++;
    @(posedge clk); #1;
    ms = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rf_we) we_seen++;
      if (wb_busy) busy_seen++;
      if (wb_rvfi.valid) pulses++;
      @(posedge clk); #1;
    end
    chk("st_hold.rvfi_pulses", 32'(pulses), 32'd1);
    chk("st_hold.rf_we_cycles", 32'(we_seen), 32'd0);
    chk("st_hold.busy_cycles", 32'(busy_seen), 32'd0);

    // Spurious responses with no entry present.
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    pulses = 0; we_seen = 0; busy_seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rf_we) we_seen++;
      if (wb_busy) busy_seen++;
      @(posedge clk); #1;
      if (wb_rvfi.valid) pulses++;
    end
    dmem_resp = 1'b0;
    chk("spur.rf_we_cycles", 32'(we_seen), 32'd0);
    chk("spur.busy_cycles", 32'(busy_seen), 32'd0);
    chk("spur.rvfi_pulses", 32'(pulses), 32'd0);

    // Load with no response: timeout after 4 wait cycles, then reset mid-wait.
    ms = '0;
    ms.rd_addr           = 5'd14;
    ms.alu_out           = 32'h0000_8000;
    ms.mem_ctrl.mem_read = 1'b1;
    ms.mem_ctrl.funct3   = 3'b010;
    ms.wb_ctrl.regf_we   = 1'b1;
    ms.rvfi.valid        = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) chk("tmo.err_before", {31'h0, timeout_err}, 32'h0);
      if (k == 5) begin
        chk("tmo.err_after", {31'h0, timeout_err}, 32'h1);
        chk("tmo.busy_still", {31'h0, wb_busy}, 32'h1);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0; ms = '0;
    #1;
    chk("tmo_rst.wb_busy", {31'h0, wb_busy}, 32'h0);
    chk("tmo_rst.timeout_err", {31'h0, timeout_err}, 32'h0);
    chk("tmo_rst.rvfi_valid", {31'h0, wb_rvfi.valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    we_seen = 0; busy_seen = 0; pulses = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rf_we) we_seen++;
      if (wb_busy) busy_seen++;
      @(posedge clk); #1;
      if (wb_rvfi.valid) pulses++;
    end
    dmem_resp = 1'b0;
    chk("stale.rf_we_cycles", 32'(we_seen), 32'd0);
    chk("stale.busy_cycles", 32'(busy_seen), 32'd0);
    chk("stale.rvfi_pulses", 32'(pulses), 32'd0);
    @(negedge clk);
    chk("stale.timeout_err", {31'h0, timeout_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
